// File: rtl/answer_round_ctrl.sv
// Buzz-in round controller: snapshots quiz settings on arming, arbitrates the
// first valid buzz, runs the answer countdown and applies the judge's verdict.
module answer_round_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               is_set_over,
  input  logic [5:0]         num_people,
  input  logic [5:0]         count_seconds,
  input  logic [5:0]         corrcet_point,
  input  logic [5:0]         mistake_point,
  input  logic               start_btn,
  input  logic               clr_btn,
  input  logic [3:0]         buzz,
  input  logic               ok_btn,
  input  logic               bad_btn,
  output logic [1:0]         state,
  output logic               winner_valid,
  output logic [1:0]         winner_id,
  output logic [5:0]         seconds_left,
  output logic               timeout,
  output logic               round_done,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [SCORE_W-1:0] score3
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [5:0]         r_np, r_cs, r_cp, r_mp;
  logic [SCORE_W-1:0] r_score [4];
  logic [PW-1:0]      r_presc;
  logic               r_winner_valid;
  logic [1:0]         r_winner_id;
  logic [5:0]         r_seconds_left;
  logic               r_timeout;
  logic               r_round_done;

  logic               w_tick;
  logic [3:0]         w_mask;
  logic [3:0]         w_buzz;
  logic [1:0]         w_first_id;
  logic [SCORE_W-1:0] w_cur;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W:0]   w_diff;
  logic [SCORE_W-1:0] w_add;
  logic [SCORE_W-1:0] w_sub;
  logic               w_ok_only;
  logic               w_bad_only;

  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_ok_only  = ok_btn & ~bad_btn;
  assign w_bad_only = bad_btn & ~ok_btn;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 4; i++) begin
      w_mask[i] = (r_np > 6'(i));
    end
  end

  assign w_buzz = buzz & w_mask;

  // Lowest unmasked index wins a simultaneous buzz.
  always_comb begin
    w_first_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_buzz[i]) w_first_id = 2'(i);
    end
  end

  // One extra bit catches overflow on add and borrow on subtract.
  assign w_cur  = r_score[r_winner_id];
  assign w_sum  = {1'b0, w_cur} + (SCORE_W+1)'(r_cp);
  assign w_diff = {1'b0, w_cur} - (SCORE_W+1)'(r_mp);
  assign w_add  = w_sum[SCORE_W]  ? '1 : w_sum[SCORE_W-1:0];
  assign w_sub  = w_diff[SCORE_W] ? '0 : w_diff[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_np           <= '0;
      r_cs           <= '0;
      r_cp           <= '0;
      r_mp           <= '0;
      r_presc        <= '0;
      r_winner_valid <= 1'b0;
      r_winner_id    <= 2'd0;
      r_seconds_left <= '0;
      r_timeout      <= 1'b0;
      r_round_done   <= 1'b0;
      for (int i = 0; i < 4; i++) r_score[i] <= '0;
    end else begin
      r_round_done <= 1'b0;
      if (r_state != S_IDLE && !is_set_over) begin
        r_state        <= S_IDLE;
        r_winner_valid <= 1'b0;
        r_seconds_left <= '0;
        r_timeout      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (clr_btn) begin
              for (int i = 0; i < 4; i++) r_score[i] <= '0;
            end
            if (start_btn && is_set_over) begin
              r_state <= S_ARMED;
              r_np    <= num_people;
              r_cs    <= count_seconds;
              r_cp    <= corrcet_point;
              r_mp    <= mistake_point;
            end
          end
          S_ARMED: begin
            if (|w_buzz) begin
              r_state        <= S_ANSWER;
              r_winner_id    <= w_first_id;
              r_winner_valid <= 1'b1;
              r_seconds_left <= r_cs;
              r_presc        <= '0;
            end
          end
          S_ANSWER: begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            // A clean verdict pre-empts any tick landing in the same cycle.
            if (w_ok_only) begin
              r_score[r_winner_id] <= w_add;
              r_state              <= S_DONE;
              r_timeout            <= 1'b0;
              r_round_done         <= 1'b1;
            end else if (w_bad_only) begin
              r_score[r_winner_id] <= w_sub;
              r_state              <= S_DONE;
              r_timeout            <= 1'b0;
              r_round_done         <= 1'b1;
            end else if (w_tick) begin
              if (r_seconds_left <= 6'd1) begin
                r_score[r_winner_id] <= w_sub;
                r_seconds_left       <= '0;
                r_state              <= S_DONE;
                r_timeout            <= 1'b1;
                r_round_done         <= 1'b1;
              end else begin
                r_seconds_left <= r_seconds_left - 6'd1;
              end
            end
          end
          S_DONE: begin
            if (start_btn && is_set_over) begin
              r_state        <= S_ARMED;
              r_winner_valid <= 1'b0;
              r_timeout      <= 1'b0;
              r_np           <= num_people;
              r_cs           <= count_seconds;
              r_cp           <= corrcet_point;
              r_mp           <= mistake_point;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign state        = r_state;
  assign winner_valid = r_winner_valid;
  assign winner_id    = r_winner_id;
  assign seconds_left = r_seconds_left;
  assign timeout      = r_timeout;
  assign round_done   = r_round_done;
  assign score0       = r_score[0];
  assign score1       = r_score[1];
  assign score2       = r_score[2];
  assign score3       = r_score[3];

endmodule

// File: tb/tb_answer_round_ctrl.sv
// Directed bench for answer_round_ctrl: expected round results are queued on
// stimulus and compared by a monitor whenever round_done pulses.
module tb_answer_round_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SW       = 8;
  localparam int MAXS     = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          is_set_over;
  logic [5:0]    num_people, count_seconds, corrcet_point, mistake_point;
  logic          start_btn, clr_btn, ok_btn, bad_btn;
  logic [3:0]    buzz;
  logic [1:0]    state;
  logic          winner_valid;
  logic [1:0]    winner_id;
  logic [5:0]    seconds_left;
  logic          timeout;
  logic          round_done;
  logic [SW-1:0] score0, score1, score2, score3;

  answer_round_ctrl #(.TICK_DIV(TICK_DIV), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .is_set_over(is_set_over),
    .num_people(num_people), .count_seconds(count_seconds),
    .corrcet_point(corrcet_point), .mistake_point(mistake_point),
    .start_btn(start_btn), .clr_btn(clr_btn), .buzz(buzz),
    .ok_btn(ok_btn), .bad_btn(bad_btn), .state(state),
    .winner_valid(winner_valid), .winner_id(winner_id),
    .seconds_left(seconds_left), .timeout(timeout), .round_done(round_done),
    .score0(score0), .score1(score1), .score2(score2), .score3(score3)
  );

  // ---------------- clock / counters ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [40:0] exp_q[$];
  logic [40:0] mon_exp, mon_act;

  int m_score[4];
  int l_np, l_cs, l_cp, l_mp;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_add(input int s, input int p);
    return (s + p > MAXS) ? MAXS : s + p;
  endfunction

  function automatic int sat_sub(input int s, input int p);
    return (s < p) ? 0 : s - p;
  endfunction

  function automatic logic [31:0] exp_scores();
    return {8'(m_score[3]), 8'(m_score[2]), 8'(m_score[1]), 8'(m_score[0])};
  endfunction

  function automatic logic [31:0] act_scores();
    return {score3, score2, score1, score0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_round();
    l_np = int'(num_people);
    l_cs = int'(count_seconds);
    l_cp = int'(corrcet_point);
    l_mp = int'(mistake_point);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("armed_state", 32'(state), 32'd1);
    check("armed_winner_valid", 32'(winner_valid), 32'd0);
    check("armed_timeout", 32'(timeout), 32'd0);
  endtask

  // v: 0 ok, 1 bad, 2 timeout, 3 ok on the expiry tick, 4 ok+bad then ok
  task automatic play(input logic [3:0] bv, input int p, input int v);
    int sl_exp;
    int to_exp;
    buzz = bv;
    tick();
    buzz = 4'd0;
    check("answer_state", 32'(state), 32'd2);
    check("answer_winner_id", 32'(winner_id), 32'(p));
    check("answer_winner_valid", 32'(winner_valid), 32'd1);
    check("answer_seconds", 32'(seconds_left), 32'(l_cs));
    if (v == 4) begin
      ok_btn = 1'b1;
      bad_btn = 1'b1;
      tick();
      ok_btn = 1'b0;
      bad_btn = 1'b0;
      check("both_verdicts_state", 32'(state), 32'd2);
      check("both_verdicts_scores", act_scores(), exp_scores());
    end
    sl_exp = l_cs;
    to_exp = 0;
    if (v == 1 || v == 2) m_score[p] = sat_sub(m_score[p], l_mp);
    else m_score[p] = sat_add(m_score[p], l_cp);
    if (v == 2) begin sl_exp = 0; to_exp = 1; end
    if (v == 3) sl_exp = 1;
    exp_q.push_back({2'(p), 6'(sl_exp), 1'(to_exp), exp_scores()});
    case (v)
      1: begin bad_btn = 1'b1; tick(); bad_btn = 1'b0; end
      2: begin
        repeat (TICK_DIV - 1) tick();
        check("sl_before_first_tick", 32'(seconds_left), 32'(l_cs));
        tick();
        check("sl_after_first_tick", 32'(seconds_left), 32'(l_cs - 1));
        for (int k = 0; k < TICK_DIV * l_cs + 4 && state != 2'd3; k++) tick();
      end
      3: begin
        repeat (TICK_DIV * l_cs - 1) tick();
        ok_btn = 1'b1; tick(); ok_btn = 1'b0;
      end
      default: begin ok_btn = 1'b1; tick(); ok_btn = 1'b0; end
    endcase
    check("done_state", 32'(state), 32'd3);
    check("done_round_done", 32'(round_done), 32'd1);
    check("done_timeout", 32'(timeout), 32'(to_exp));
    tick();
    check("round_done_one_cycle", 32'(round_done), 32'd0);
    check("done_hold_state", 32'(state), 32'd3);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (round_done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL round_result: round_done pulsed with nothing expected");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_act = {winner_id, seconds_left, timeout, score3, score2, score1, score0};
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL round_result: got %h, expected %h (id,secs,timeout,s3..s0)",
                   mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) m_score[i] = 0;
    rst = 1'b1; is_set_over = 1'b0;
    num_people = 6'd0; count_seconds = 6'd0; corrcet_point = 6'd0; mistake_point = 6'd0;
    start_btn = 1'b0; clr_btn = 1'b0; ok_btn = 1'b0; bad_btn = 1'b0; buzz = 4'd0;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_winner_valid", 32'(winner_valid), 32'd0);
    check("rst_winner_id", 32'(winner_id), 32'd0);
    check("rst_seconds", 32'(seconds_left), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_round_done", 32'(round_done), 32'd0);
    check("rst_scores", act_scores(), 32'd0);
    rst = 1'b0;
    tick();

    // Round 1: 3 players, simultaneous buzz from players 1 and 2
    num_people = 6'd3; count_seconds = 6'd5; corrcet_point = 6'd2; mistake_point = 6'd1;
    is_set_over = 1'b1;
    start_round();
    play(4'b0110, 1, 0);

    // Round 2: 2 players, player 3 buzz must be masked
    num_people = 6'd2;
    start_round();
    buzz = 4'b1000; tick(); buzz = 4'd0;
    check("masked_buzz_state", 32'(state), 32'd1);
    play(4'b0001, 0, 1);

    // Round 3: countdown to expiry; input change mid-round must not matter
    num_people = 6'd3; count_seconds = 6'd2;
    start_round();
    count_seconds = 6'd9;
    play(4'b0100, 2, 2);

    // Rounds 4..: drive player 3 towards saturation, then a penalty
    num_people = 6'd4; count_seconds = 6'd5; corrcet_point = 6'd63;
    for (int r = 0; r < 4; r++) begin
      start_round();
      play(4'b1000, 3, 0);
    end
    corrcet_point = 6'd2;
    start_round(); play(4'b1000, 3, 0);
    corrcet_point = 6'd5;
    start_round(); play(4'b1000, 3, 0);
    check("score3_saturated", 32'(score3), 32'd255);
    mistake_point = 6'd3;
    start_round(); play(4'b1000, 3, 1);

    // Simultaneous ok+bad ignored, then a clean ok
    start_round(); play(4'b0010, 1, 4);

    // ok on the exact expiry tick: verdict wins
    count_seconds = 6'd1;
    start_round(); play(4'b0001, 0, 3);

    // Abort mid-answer, ignored start, clear
    count_seconds = 6'd5;
    start_round();
    buzz = 4'b0010; tick(); buzz = 4'd0;
    check("abort_pre_state", 32'(state), 32'd2);
    is_set_over = 1'b0;
    tick();
    check("abort_state", 32'(state), 32'd0);
    check("abort_winner_valid", 32'(winner_valid), 32'd0);
    check("abort_seconds", 32'(seconds_left), 32'd0);
    check("abort_timeout", 32'(timeout), 32'd0);
    check("abort_scores_kept", act_scores(), exp_scores());
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    check("start_while_editing", 32'(state), 32'd0);
    clr_btn = 1'b1; tick(); clr_btn = 1'b0;
    for (int i = 0; i < 4; i++) m_score[i] = 0;
    check("clear_scores", act_scores(), exp_scores());
    is_set_over = 1'b1;
    start_round();

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/answer_round_ctrl.md
Name: answer_round_ctrl

Overview:
- Consumes the four quiz settings once setup reports done, then runs buzz-in rounds for up to 4 players.
- Per round: arbitrates the first valid buzz and runs the answer countdown. Applies the judge's verdict as a score change.
- Sits between the settings block and the display/speaker logic in the multichannel answering machine top level.

Parameters:
TICK_DIV, 100000000, clk cycles per countdown second; the bench uses 4.
SCORE_W, 8, score width in bits; unsigned, saturating.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
is_set_over  input  1  setup complete; low means settings are being edited
num_people  input  6  active players, 2..4
count_seconds  input  6  answer window in seconds, >=1
corrcet_point  input  6  points added on correct
mistake_point  input  6  points removed on wrong/timeout
start_btn  input  1  one-cycle pulse (debounced upstream): arm a round
clr_btn  input  1  one-cycle pulse: clear all scores (IDLE only)
buzz  input  4  one-cycle buzz pulses, bit i = player i
ok_btn  input  1  one-cycle pulse: judge says correct
bad_btn  input  1  one-cycle pulse: judge says wrong
state  output  2  0 IDLE, 1 ARMED, 2 ANSWER, 3 DONE
winner_valid  output  1  high in ANSWER and DONE
winner_id  output  2  index of the answering player
seconds_left  output  6  remaining answer seconds
timeout  output  1  high in DONE if the round ended by expiry
round_done  output  1  one-cycle pulse on DONE entry
score0..score3  output  SCORE_W each  player scores

Behaviour:
- Reset: state=IDLE, all scores=0, winner_valid=0, winner_id=0, seconds_left=0, timeout=0, round_done=0, prescaler=0.
- Settings snapshot:
  - num_people, count_seconds, corrcet_point and mistake_point are latched into internal registers on the IDLE->ARMED transition.
  - Input changes mid-round have no effect.
- IDLE:
  - clr_btn zeroes all scores next cycle.
  - start_btn with is_set_over=1 -> ARMED.
  - start_btn with is_set_over=0 is ignored.
- ARMED:
  - buzz bits for players with index >= latched num_people are masked.
  - Any unmasked buzz -> ANSWER next cycle. winner_id = lowest set unmasked index; winner_valid=1; seconds_left = latched count_seconds; prescaler cleared.
- ANSWER:
  - Prescaler counts 0..TICK_DIV-1. A tick occurs on wrap, so the first decrement lands TICK_DIV cycles after ANSWER entry.
  - Tick decrements seconds_left.
  - Expiry: a tick while seconds_left==1 sets seconds_left=0, state=DONE, timeout=1, and applies the penalty.
  - ok_btn alone: score[winner] += corrcet_point, saturating at 2^SCORE_W-1 -> DONE, timeout=0.
  - bad_btn alone: score[winner] -= mistake_point, floored at 0 -> DONE, timeout=0.
  - ok_btn and bad_btn in the same cycle: both ignored, no state change.
  - Verdict in the same cycle as an expiry tick: the verdict wins; the tick is discarded and timeout=0.
  - buzz inputs are ignored.
- DONE:
  - round_done=1 for the entry cycle only.
  - Holds winner_id, seconds_left and timeout until start_btn.
  - start_btn with is_set_over=1 -> ARMED: winner_valid=0, timeout=0, settings re-latched.
- is_set_over falls in any state -> IDLE next cycle; winner_valid=0, seconds_left=0, timeout=0; scores preserved.
- Reset has priority over all events; rst mid-round returns to the reset values the next cycle.
- Score arithmetic is done at SCORE_W+1 bits, then clamped. All outputs are registered.

Test Plan:
- Reset, settings 3/5/2/1, is_set_over=1, start_btn, then buzz=4'b0110 in one cycle -> winner_id=1, seconds_left=5, state=ANSWER; then ok_btn -> score1=2, round_done pulse, timeout=0.
- num_people=2, ARMED, buzz=4'b1000 -> no transition. Then buzz=4'b0001 -> winner_id=0.
- TICK_DIV=4, count_seconds=2, winner player 2 with score2=0, no verdict -> seconds_left 2->1 at cycle 4 and 1->0 at cycle 8; DONE, timeout=1, score2 stays 0 (floor).
- score3=254, corrcet_point=5, player 3 correct -> score3=255. Next round, mistake_point=3, bad_btn -> score3=252.
- ok_btn+bad_btn same cycle -> state stays ANSWER, scores unchanged. Later, ok_btn on the exact expiry tick -> score increases, timeout=0.
- is_set_over dropped in ANSWER -> IDLE next cycle, scores intact. start_btn with is_set_over=0 ignored. clr_btn in IDLE -> all scores 0.
